// File: rtl/ccd_pixel_packer_if.sv
// rtl/ccd_pixel_packer_if.sv - req/out/accept word handshake toward one tx_mux priority input
interface ccd_pixel_packer_if;
   logic        req;
   logic [15:0] out;
   logic        accept;

   modport master (output req, output out, input accept);
   modport slave  (input req, input out, output accept);
endinterface

// File: rtl/ccd_pixel_packer.sv
// rtl/ccd_pixel_packer.sv - CCD pixel/strobe capture with marker insertion, word FIFO and drop counting
module ccd_pixel_packer #(
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [15:0] CLAMP_MAX  = 16'hFFFB
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  frame_start,
   input  logic                  line_end,
   input  logic                  pix_valid,
   input  logic [15:0]           pix_data,
   ccd_pixel_packer_if.master    tx,
   output logic [DEPTH_LOG2:0]   level,
   output logic [15:0]           drop_cnt,
   output logic                  overflow,
   input  logic                  drop_clr
);
   localparam int                DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [15:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_n;
   logic [15:0]           frame_cnt, out_r, w0, w1, head_n, base_cnt;
   logic [DEPTH_LOG2:0]   free, level_n, remain;
   logic [1:0]            n_push, n_drop;
   logic                  fc_inc, pop;
   logic [16:0]           drop_sum;

   always_comb begin
      n_push = 2'd0;
      n_drop = 2'd0;
      w0     = 16'h0000;
      w1     = 16'h0000;
      fc_inc = 1'b0;
      free   = DEPTH_W - level;
      // Only the highest-priority strobe is serviced; lower ones that fired are lost.
      if (en) begin
         if (frame_start) begin
            fc_inc = 1'b1;
            w0     = 16'hFFFF;
            w1     = frame_cnt;
            n_push = (free >= (DEPTH_LOG2 + 1)'(2)) ? 2'd2 : 2'd0;
            n_drop = 2'(free < (DEPTH_LOG2 + 1)'(2)) + 2'(line_end) + 2'(pix_valid);
         end else if (line_end) begin
            w0     = 16'hFFFE;
            n_push = (free != '0) ? 2'd1 : 2'd0;
            n_drop = 2'(free == '0) + 2'(pix_valid);
         end else if (pix_valid) begin
            w0     = (pix_data > CLAMP_MAX) ? CLAMP_MAX : pix_data;
            n_push = (free != '0) ? 2'd1 : 2'd0;
            n_drop = 2'(free == '0);
         end
      end
      pop     = tx.accept && (level != '0);
      level_n = level + (DEPTH_LOG2 + 1)'(n_push) - (DEPTH_LOG2 + 1)'(pop);
      rd_n    = rd_ptr + DEPTH_LOG2'(pop);
      remain  = level - (DEPTH_LOG2 + 1)'(pop);
      // With nothing older left after the pop, the new head is this cycle's first write.
      head_n  = (remain == '0) ? w0 : mem[rd_n];
      base_cnt = drop_clr ? 16'h0000 : drop_cnt;
      drop_sum = {1'b0, base_cnt} + 17'(n_drop);
   end

   always_ff @(posedge clk) begin
      if (n_push != 2'd0) mem[wr_ptr] <= w0;
      if (n_push == 2'd2) mem[wr_ptr + DEPTH_LOG2'(1)] <= w1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_r     <= 16'h0000;
         frame_cnt <= 16'h0000;
         drop_cnt  <= 16'h0000;
         overflow  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + DEPTH_LOG2'(n_push);
         rd_ptr <= rd_n;
         level  <= level_n;
         if (level_n != '0) out_r <= head_n;
         if (fc_inc) frame_cnt <= frame_cnt + 16'd1;
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         overflow <= (overflow && !drop_clr) || (n_drop != 2'd0);
      end
   end

   assign tx.req = (level != '0);
   assign tx.out = out_r;
endmodule

// File: doc/ccd_pixel_packer.md
Name: ccd_pixel_packer

Overview:
- Upstream stage of tx_mux. Takes CCD ADC pixel samples plus frame/line timing strobes.
- Inserts reserved marker words and buffers everything in a small internal word FIFO.
- Presents the stream on one tx_mux priority input using the req/accept handshake.
- Drops and counts input when the buffer cannot absorb it, so the readout timing never stalls.

Parameters:
- DEPTH_LOG2, 4, internal FIFO depth is 2**DEPTH_LOG2 words (default 16).
- CLAMP_MAX, 16'hFFFB, largest pixel value passed through; anything larger is clamped to this.

Ports:
- clk  input  1  system clock (same clock as tx_mux write side).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when low all input strobes are ignored and not counted.
- frame_start  input  1  one-cycle strobe at start of frame.
- line_end  input  1  one-cycle strobe at end of line.
- pix_valid  input  1  pix_data valid this cycle.
- pix_data  input  16  ADC sample.
- req  output  1  word available to tx_mux (connects to a req[n] bit).
- out  output  16  word presented to tx_mux (connects to in_n).
- accept  input  1  tx_mux consumed out this cycle (accept[n]).
- level  output  DEPTH_LOG2+1  words currently buffered.
- drop_cnt  output  16  count of dropped events, saturating at 16'hFFFF.
- overflow  output  1  sticky: at least one drop since reset or drop_clr.
- drop_clr  input  1  synchronous clear of drop_cnt and overflow.

Behaviour:
- Reset (async, rst_n low) forces: req=0, out=16'h0000, level=0, drop_cnt=0, overflow=0, frame counter=0, FIFO pointers=0. Release is taken on the next clk edge.
- Reserved marker words:
  - 16'hFFFF = frame start.
  - 16'hFFFE = line end.
  - Pixels are min(pix_data, CLAMP_MAX), so markers are never ambiguous.
- Input priority when several strobes are high in the same cycle: frame_start > line_end > pix_valid. Only the winner is considered. Each lower strobe that is also high counts as one drop.
- frame_start event:
  - Needs 2 free slots.
  - Enqueues 16'hFFFF, then the frame counter value (16-bit), in that order, both in the same cycle.
  - Frame counter then increments and wraps 16'hFFFF -> 16'h0000. The first frame after reset carries number 0.
  - If fewer than 2 slots are free, nothing is enqueued, the counter still increments, and the event counts as a drop.
- line_end event: needs 1 free slot, enqueues 16'hFFFE; otherwise counts as a drop.
- pix_valid event: needs 1 free slot, enqueues the clamped pixel; otherwise counts as a drop.
- Free-slot check uses level at the start of the cycle. A pop in the same cycle does not create space for that cycle's write.
- Write-to-visible latency:
  - A word enqueued at edge N into an empty FIFO gives req=1 with out=that word after edge N.
  - tx_mux can sample it from cycle N+1.
- Output handshake:
  - req = (level != 0). out = FIFO head; out holds its value whenever req=0 or accept=0.
  - accept && req at an edge pops one word; the next word (if any) is presented immediately after that edge.
  - accept while req=0 is ignored.
  - req may stay high back-to-back; one pop per cycle at most.
- Simultaneous push and pop: level += pushes - pops (range -1..+2). Pointers wrap modulo depth. level never exceeds 2**DEPTH_LOG2.
- Drop counting:
  - drop_cnt increments by the number of drops in the cycle (0..3) and saturates.
  - overflow is set on any drop.
  - drop_clr clears both. If a drop occurs in the same cycle as drop_clr, the result is drop_cnt = drops this cycle and overflow = 1.
- en=0: no enqueue, no drops counted, frame counter frozen; draining via accept continues.
- Reset mid-stream: buffered words are discarded; req falls asynchronously.

Test Plan:
- Reset then frame_start, 3 pixels 16'h0010/16'h0020/16'h0030, line_end, accept held high -> out sequence FFFF, 0000, 0010, 0020, 0030, FFFE; req low afterwards; drop_cnt=0.
- Pixel 16'hFFFF and 16'hFFFC with accept high -> both emitted as 16'hFFFB; 16'hFFFB itself emitted unchanged.
- accept held low, 17 pix_valid with DEPTH_LOG2=4 -> level=16, drop_cnt=1, overflow=1. With 15 words buffered, frame_start -> dropped, drop_cnt=2; the next accepted frame header shows frame number 1.
- frame_start, line_end and pix_valid high in the same cycle with empty FIFO -> only FFFF and counter enqueued; drop_cnt=2. drop_clr with a simultaneous drop -> drop_cnt=1.
- Full FIFO with accept and pix_valid in the same cycle -> pixel dropped, level goes 16->15. The next cycle's pix_valid is accepted, level=16.
- 65536 frame_starts (accept high) -> 65537th header carries 16'h0000. rst_n pulsed low mid-drain -> req=0, level=0 immediately.
